player_controller: RTL and testbench
====================================

# player_controller

Sequencer and state machine for the dino player. Once per game frame it issues the two-phase `game_tick` pulses that drive the player physics datapath (velocity phase, then position phase). It turns button presses into a single-cycle `jump_pulse` and tracks the player state (idle, run, jump, duck, dead). It sits between the input debouncers and frame timing on one side, and the physics block and sprite renderer on the other.

## Interface
Parameters:
- `DEAD_HOLD_FRAMES`, 30: frames spent in DEAD before a restart press is accepted.
- `ANIM_DIV`, 6: frames per toggle of the run/duck animation bit.

Ports:
- `clk` input 1: system clock; the only clock.
- `reset_n` input 1: reset, asynchronous, active-low.
- `frame_start` input 1: one-cycle pulse at the start of each game frame.
- `button_up` input 1: debounced, synchronous jump button level.
- `button_down` input 1: debounced, synchronous duck button level.
- `collision` input 1: level from the obstacle logic, sampled every cycle.
- `jump_done` input 1: landing flag from physics; valid only while `game_tick[1]`=1.
- `game_tick` output 2: bit0 = velocity phase, bit1 = position phase; one-hot or zero.
- `jump_pulse` output 1: one-cycle jump start to physics.
- `phys_down` output 1: fast-drop/duck request to physics.
- `phys_rst_n` output 1: active-low, one-cycle physics clear on restart.
- `player_state` output 3: current state encoding from the package.
- `anim_frame` output 1: sprite animation phase.
- `game_over` output 1: high while in DEAD.

## Operation
- States: IDLE, RUN, JUMP, DUCK, DEAD.
- Reset values:
  - state = IDLE, `game_tick`=0, `jump_pulse`=0, `phys_rst_n`=1, `anim_frame`=0, `game_over`=0.
  - Dead counter = 0, jump-edge latch = 0.
- Up-press rising edge: detected against the previous sample of `button_up`.
  - The edge sets a jump latch.
  - The latch clears when consumed, or at the next `frame_start` if not consumed.
- Tick sequencing:
  - `frame_start` in cycle N gives `game_tick`=01 in N+1 and 10 in N+2, then 00.
  - A `frame_start` that arrives during N+1 or N+2 is ignored.
  - No ticks are issued in IDLE or DEAD.
- IDLE: an up-press edge goes to RUN and pulses `phys_rst_n` low for one cycle.
- RUN:
  - `button_down` goes to DUCK at once.
  - Otherwise, a set jump latch raises `jump_pulse` in the `game_tick[0]` cycle, clears the latch and goes to JUMP on that edge.
  - If down and up are both present, down wins.
- DUCK: `button_down` low returns to RUN. Jump is not possible from DUCK.
- JUMP:
  - In the `game_tick[1]` cycle with `jump_done`=1, go to RUN, or to DUCK if `button_down` is high.
  - Up-presses while airborne are discarded (see Configuration).
- `phys_down` = `button_down` && (state == JUMP or DUCK).
- `collision`=1 in any of RUN, JUMP or DUCK goes to DEAD on the next edge and has priority over every other transition.
  - Any tick sequence in flight is aborted; `game_tick` is 00 from that edge.
- DEAD:
  - The counter increments on each `frame_start`, saturating at `DEAD_HOLD_FRAMES`.
  - An up-press edge with counter = `DEAD_HOLD_FRAMES` goes to RUN, pulses `phys_rst_n` and clears the counter.
  - Earlier presses are discarded.
- `anim_frame`:
  - A frame counter counts 0..`ANIM_DIV`-1 on `frame_start` in RUN or DUCK and toggles `anim_frame` on wrap.
  - The counter is held in JUMP and cleared in IDLE and DEAD.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `jump_pulse` is coincident with `game_tick[0]`.
- Latency from up-press to `jump_pulse`: up to one frame + 1 cycle.
- `jump_done` is ignored outside `game_tick[1]` cycles.
- Asserting reset mid-sequence clears state immediately (asynchronous); no tick completes.

## Configuration
- `JUMP_BUFFER_EN` defined:
  - An up-press edge in JUMP sets a buffer flag.
  - On the landing transition to RUN the flag is kept as a set jump latch, so the next frame's `game_tick[0]` fires `jump_pulse`.
  - The flag is cleared on landing into DUCK, on DEAD and on reset.
- Not defined: up-presses in JUMP are discarded and no buffer flag exists.

## Structure
- `player_pkg`: state enum (IDLE=0, RUN=1, JUMP=2, DUCK=3, DEAD=4) and tick-phase constants (`TICK_VEL`=2'b01, `TICK_POS`=2'b10).
- Sub-module `rise_detect`: registered previous sample plus rising-edge output, instantiated for `button_up`.

## Test plan
- Reset, then press up: state IDLE→RUN, `phys_rst_n` low for one cycle; `frame_start` at N gives `game_tick` 01@N+1, 10@N+2.
- In RUN, up-press then `frame_start`: `jump_pulse`=1 only in the `game_tick`=01 cycle, state JUMP; `jump_done`=1 at the next 10 cycle gives RUN.
- Collision during `game_tick`=01: DEAD on the next edge, `game_tick`=00, `game_over`=1; up-press at frame 10 is ignored; up-press at frame 30 gives RUN plus `phys_rst_n` pulse.
- Up and down held together in RUN: DUCK, no `jump_pulse`, `phys_down`=1; release both gives RUN.
- Up-press mid-JUMP: without `JUMP_BUFFER_EN`, no pulse after landing; with it, `jump_pulse` fires at the first `game_tick`=01 after landing.
- Second `frame_start` one cycle after the first is ignored (exactly one 01/10 pair); with `ANIM_DIV`=6, `anim_frame` toggles every 6 frames in RUN.

Source files
------------

// File: rtl/player_pkg.sv
// player_pkg: shared encodings for the dino player controller.
//   state_e  : player state (IDLE=0, RUN=1, JUMP=2, DUCK=3, DEAD=4)
//   TICK_VEL : game_tick value for the velocity phase
//   TICK_POS : game_tick value for the position phase
package player_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RUN  = 3'd1,
        JUMP = 3'd2,
        DUCK = 3'd3,
        DEAD = 3'd4
    } state_e;

    localparam logic [1:0] TICK_VEL = 2'b01;
    localparam logic [1:0] TICK_POS = 2'b10;

endpackage

// File: rtl/rise_detect.sv
// rise_detect: registers the previous sample of a synchronous level and
// flags the cycle in which it goes from 0 to 1.
//   clk    : clock
//   rst_n  : asynchronous active-low reset (previous sample clears to 0)
//   d_i    : synchronous level input
//   rise_o : high in the first cycle d_i is 1 after being 0
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic rise_o
);

    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_q <= 1'b0;
        else        prev_q <= d_i;
    end

    assign rise_o = d_i & ~prev_q;

endmodule

// File: rtl/player_controller.sv
// player_controller: per-frame tick sequencer and state machine for the
// dino player. Issues the velocity/position game_tick pair after each
// accepted frame_start, turns up-button edges into jump_pulse, and tracks
// IDLE/RUN/JUMP/DUCK/DEAD. Every output comes straight from a register.
//
// Optional feature: define JUMP_BUFFER_EN to remember an up-press made
// while airborne and fire it on the first frame after landing in RUN.
//
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   frame_start    : one-cycle pulse per game frame
//   button_up/down : debounced button levels
//   collision      : obstacle hit level
//   jump_done      : landing flag, looked at only in the position-tick cycle
//   game_tick      : 01 velocity phase, 10 position phase, else 00
//   jump_pulse     : one-cycle jump start, coincident with game_tick=01
//   phys_down      : fast-drop / duck request
//   phys_rst_n     : one-cycle active-low physics clear on (re)start
//   player_state   : state_e encoding
//   anim_frame     : sprite animation phase
//   game_over      : high while in DEAD
module player_controller
    import player_pkg::*;
#(
    parameter int DEAD_HOLD_FRAMES = 30,
    parameter int ANIM_DIV         = 6
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_start,
    input  logic       button_up,
    input  logic       button_down,
    input  logic       collision,
    input  logic       jump_done,
    output logic [1:0] game_tick,
    output logic       jump_pulse,
    output logic       phys_down,
    output logic       phys_rst_n,
    output logic [2:0] player_state,
    output logic       anim_frame,
    output logic       game_over
);

    localparam int DCW = $clog2(DEAD_HOLD_FRAMES + 1);
    localparam int ACW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [DCW-1:0] DEAD_MAX = DCW'(DEAD_HOLD_FRAMES);
    localparam logic [ACW-1:0] ANIM_MAX = ACW'(ANIM_DIV - 1);

    state_e           state_q;
    logic [1:0]       tick_q;
    logic             jump_pulse_q;
    logic             phys_down_q;
    logic             phys_rst_n_q;
    logic             anim_q;
    logic             game_over_q;
    logic             jlatch_q;
    logic [DCW-1:0]   dead_cnt_q;
    logic [ACW-1:0]   anim_cnt_q;
`ifdef JUMP_BUFFER_EN
    logic             buf_q;
`endif

    logic up_rise;
    logic frame_edge;   // frame_start that is not landing inside a tick pair
    logic active;       // states that run physics and can collide
    logic collide;

    rise_detect u_up_rise (
        .clk    (clk),
        .rst_n  (reset_n),
        .d_i    (button_up),
        .rise_o (up_rise)
    );

    assign frame_edge = frame_start && (tick_q == 2'b00);
    assign active     = state_q inside {RUN, JUMP, DUCK};
    assign collide    = active && collision;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            tick_q       <= 2'b00;
            jump_pulse_q <= 1'b0;
            phys_down_q  <= 1'b0;
            phys_rst_n_q <= 1'b1;
            anim_q       <= 1'b0;
            game_over_q  <= 1'b0;
            jlatch_q     <= 1'b0;
            dead_cnt_q   <= '0;
            anim_cnt_q   <= '0;
`ifdef JUMP_BUFFER_EN
            buf_q        <= 1'b0;
`endif
        end else begin
            jump_pulse_q <= 1'b0;
            phys_rst_n_q <= 1'b1;
            phys_down_q  <= button_down && (state_q inside {JUMP, DUCK});

            // Tick pair: 01 then 10; further frame_starts are ignored meanwhile.
            if (collide)                 tick_q <= 2'b00;
            else if (tick_q == TICK_VEL) tick_q <= TICK_POS;
            else if (tick_q == TICK_POS) tick_q <= 2'b00;
            else if (frame_start && active) tick_q <= TICK_VEL;

            // Jump latch lives for at most one frame; only RUN/DUCK arm it.
            if (frame_edge)
                jlatch_q <= 1'b0;
            else if (up_rise && (state_q inside {RUN, DUCK}))
                jlatch_q <= 1'b1;

            if (state_q inside {IDLE, DEAD})
                anim_cnt_q <= '0;
            else if (frame_edge && (state_q inside {RUN, DUCK})) begin
                if (anim_cnt_q == ANIM_MAX) begin
                    anim_cnt_q <= '0;
                    anim_q     <= ~anim_q;
                end else begin
                    anim_cnt_q <= anim_cnt_q + 1'b1;
                end
            end

            if (state_q != DEAD)
                dead_cnt_q <= '0;
            else if (frame_start && (dead_cnt_q != DEAD_MAX))
                dead_cnt_q <= dead_cnt_q + 1'b1;

            if (collide) begin
                state_q     <= DEAD;
                game_over_q <= 1'b1;
                jlatch_q    <= 1'b0;
`ifdef JUMP_BUFFER_EN
                buf_q       <= 1'b0;
`endif
            end else begin
                case (state_q)
                    IDLE: if (up_rise) begin
                        state_q      <= RUN;
                        phys_rst_n_q <= 1'b0;
                    end
                    RUN: begin
                        if (button_down)
                            state_q <= DUCK;
                        else if (frame_edge && (jlatch_q || up_rise)) begin
                            // Decided one edge early so the pulse lines up with tick 01.
                            state_q      <= JUMP;
                            jump_pulse_q <= 1'b1;
                            jlatch_q     <= 1'b0;
                        end
                    end
                    DUCK: if (!button_down) state_q <= RUN;
                    JUMP: begin
                        if ((tick_q == TICK_POS) && jump_done) begin
                            if (button_down) begin
                                state_q <= DUCK;
                            end else begin
                                state_q <= RUN;
`ifdef JUMP_BUFFER_EN
                                if (buf_q || up_rise) jlatch_q <= 1'b1;
`endif
                            end
`ifdef JUMP_BUFFER_EN
                            buf_q <= 1'b0;
`endif
                        end
`ifdef JUMP_BUFFER_EN
                        else if (up_rise) buf_q <= 1'b1;
`endif
                    end
                    DEAD: if (up_rise && (dead_cnt_q == DEAD_MAX)) begin
                        state_q      <= RUN;
                        phys_rst_n_q <= 1'b0;
                        game_over_q  <= 1'b0;
                        dead_cnt_q   <= '0;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign game_tick    = tick_q;
    assign jump_pulse   = jump_pulse_q;
    assign phys_down    = phys_down_q;
    assign phys_rst_n   = phys_rst_n_q;
    assign player_state = state_q;
    assign anim_frame   = anim_q;
    assign game_over    = game_over_q;

endmodule

// File: tb/tb_player_controller.sv
module tb_player_controller;

    localparam int HOLD = 30;
    localparam int ADIV = 6;
    localparam int S_IDLE = 0, S_RUN = 1, S_JUMP = 2, S_DUCK = 3, S_DEAD = 4;
`ifdef JUMP_BUFFER_EN
    localparam bit BUF_EN = 1'b1;
`else
    localparam bit BUF_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       frame_start = 1'b0, button_up = 1'b0, button_down = 1'b0;
    logic       collision = 1'b0, jump_done = 1'b0;
    logic [1:0] game_tick;
    logic       jump_pulse, phys_down, phys_rst_n, anim_frame, game_over;
    logic [2:0] player_state;

    int n_cmp = 0;
    int n_bad = 0;

    player_controller #(.DEAD_HOLD_FRAMES(HOLD), .ANIM_DIV(ADIV)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .frame_start  (frame_start),
        .button_up    (button_up),
        .button_down  (button_down),
        .collision    (collision),
        .jump_done    (jump_done),
        .game_tick    (game_tick),
        .jump_pulse   (jump_pulse),
        .phys_down    (phys_down),
        .phys_rst_n   (phys_rst_n),
        .player_state (player_state),
        .anim_frame   (anim_frame),
        .game_over    (game_over)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // phase = cycles into the current tick pair (0 = none, 1 = velocity, 2 = position)
    int m_st = S_IDLE, m_phase = 0, m_dead = 0, m_frames = 0;
    bit m_prev_up = 0, m_armed = 0, m_buf = 0, m_pulse = 0, m_prst = 1, m_pd = 0, m_anim = 0;

    always @(posedge clk or negedge reset_n) begin : model
        int  nxt, nphase, nframes, ndead;
        bit  rise, accepted, live, nar, nbuf, nanim, pulse, prst;
        if (!reset_n) begin
            m_st <= S_IDLE; m_phase <= 0; m_dead <= 0; m_frames <= 0;
            m_prev_up <= 0; m_armed <= 0; m_buf <= 0; m_pulse <= 0;
            m_prst <= 1; m_pd <= 0; m_anim <= 0;
        end else begin
            rise     = button_up && !m_prev_up;
            accepted = frame_start && (m_phase == 0);
            live     = (m_st == S_RUN) || (m_st == S_JUMP) || (m_st == S_DUCK);
            nxt = m_st; pulse = 0; prst = 1;
            nar = m_armed; nbuf = m_buf; nanim = m_anim;
            nframes = m_frames; ndead = m_dead;

            if (live && collision) nphase = 0;
            else if (m_phase != 0) nphase = (m_phase + 1) % 3;
            else nphase = (frame_start && live) ? 1 : 0;

            if (accepted) nar = 0;
            else if (rise && (m_st == S_RUN || m_st == S_DUCK)) nar = 1;

            if (m_st == S_IDLE || m_st == S_DEAD) nframes = 0;
            else if (accepted && (m_st == S_RUN || m_st == S_DUCK)) begin
                nframes = (m_frames + 1) % ADIV;
                if (nframes == 0) nanim = !m_anim;
            end

            if (m_st != S_DEAD) ndead = 0;
            else if (frame_start) ndead = (m_dead < HOLD) ? m_dead + 1 : HOLD;

            if (live && collision) begin
                nxt = S_DEAD; nar = 0; nbuf = 0;
            end else if (m_st == S_IDLE) begin
                if (rise) begin nxt = S_RUN; prst = 0; end
            end else if (m_st == S_RUN) begin
                if (button_down) nxt = S_DUCK;
                else if (accepted && (m_armed || rise)) begin nxt = S_JUMP; pulse = 1; nar = 0; end
            end else if (m_st == S_DUCK) begin
                if (!button_down) nxt = S_RUN;
            end else if (m_st == S_JUMP) begin
                if (m_phase == 2 && jump_done) begin
                    nxt = button_down ? S_DUCK : S_RUN;
                    if (BUF_EN && nxt == S_RUN && (m_buf || rise)) nar = 1;
                    nbuf = 0;
                end else if (BUF_EN && rise) nbuf = 1;
            end else if (m_st == S_DEAD) begin
                if (rise && m_dead == HOLD) begin nxt = S_RUN; prst = 0; ndead = 0; end
            end

            m_pd      <= button_down && (m_st == S_JUMP || m_st == S_DUCK);
            m_st      <= nxt;   m_phase <= nphase; m_dead <= ndead; m_frames <= nframes;
            m_prev_up <= button_up; m_armed <= nar; m_buf <= nbuf;
            m_pulse   <= pulse; m_prst <= prst; m_anim <= nanim;
        end
    end

    function automatic logic [10:0] model_vec();
        logic [1:0] t;
        t = (m_phase == 1) ? 2'b01 : (m_phase == 2) ? 2'b10 : 2'b00;
        return {3'(m_st), t, m_pulse, m_pd, m_prst, m_anim, (m_st == S_DEAD)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // cycle-by-cycle compare against the model
    always @(negedge clk) begin
        chk("outputs{st,tick,jp,pd,prst,anim,go}",
            {player_state, game_tick, jump_pulse, phys_down, phys_rst_n, anim_frame, game_over},
            model_vec());
    end

    // drive one cycle of inputs, then look 1 unit after the edge
    task automatic step(input bit fs, input bit bu, input bit bd, input bit col, input bit jd);
        frame_start = fs; button_up = bu; button_down = bd; collision = col; jump_done = jd;
        @(posedge clk); #1;
    endtask

    initial begin
        int toggles;
        bit last;

        repeat (3) step(0, 0, 0, 0, 0);
        chk("reset state", player_state, 0);
        chk("reset tick", game_tick, 0);
        chk("reset phys_rst_n", phys_rst_n, 1);
        chk("reset game_over", game_over, 0);
        chk("reset jump_pulse", jump_pulse, 0);
        chk("reset anim", anim_frame, 0);
        reset_n = 1'b1;
        step(0, 0, 0, 0, 0);

        // start
        step(0, 1, 0, 0, 0);
        chk("start state", player_state, S_RUN);
        chk("start phys_rst_n low", phys_rst_n, 0);
        step(0, 1, 0, 0, 0);
        chk("phys_rst_n one cycle", phys_rst_n, 1);
        step(1, 1, 0, 0, 0); chk("tick N+1", game_tick, 2'b01);
        step(0, 1, 0, 0, 0); chk("tick N+2", game_tick, 2'b10);
        step(0, 1, 0, 0, 0); chk("tick N+3", game_tick, 2'b00);

        // jump
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        chk("jump tick", game_tick, 2'b01);
        chk("jump pulse", jump_pulse, 1);
        chk("jump state", player_state, S_JUMP);
        step(0, 1, 0, 0, 0);
        chk("jump pulse one cycle", jump_pulse, 0);
        step(0, 1, 0, 0, 1);
        chk("land state", player_state, S_RUN);

        // back-to-back frame_start gives one pair only
        step(1, 0, 0, 0, 0); chk("dbl fs tick1", game_tick, 2'b01);
        step(1, 0, 0, 0, 0); chk("dbl fs tick2", game_tick, 2'b10);
        step(0, 0, 0, 0, 0); chk("dbl fs tick3", game_tick, 2'b00);
        step(0, 0, 0, 0, 0); chk("dbl fs tick4", game_tick, 2'b00);

        // up + down together: down wins
        step(0, 1, 1, 0, 0); chk("updown state", player_state, S_DUCK);
        step(0, 1, 1, 0, 0); chk("updown phys_down", phys_down, 1);
        step(1, 1, 1, 0, 0); chk("duck no pulse", jump_pulse, 0);
        step(0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0); chk("release state", player_state, S_RUN);

        // collision mid-sequence
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        chk("dead state", player_state, S_DEAD);
        chk("dead tick", game_tick, 2'b00);
        chk("dead game_over", game_over, 1);
        for (int i = 0; i < 10; i++) begin step(1, 0, 0, 0, 0); step(0, 0, 0, 0, 0); end
        step(0, 1, 0, 0, 0); chk("early press ignored", player_state, S_DEAD);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin step(1, 0, 0, 0, 0); step(0, 0, 0, 0, 0); end
        step(0, 1, 0, 0, 0);
        chk("restart state", player_state, S_RUN);
        chk("restart phys_rst_n", phys_rst_n, 0);

        // up-press while airborne
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0); chk("air jump pulse", jump_pulse, 1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 1); chk("air land", player_state, S_RUN);
        step(0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0); chk("buffered jump", jump_pulse, BUF_EN);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1); chk("settle RUN", player_state, S_RUN);

        // animation: 12 RUN frames give exactly two toggles
        toggles = 0;
        last = anim_frame;
        for (int f = 0; f < 12; f++) begin
            for (int c = 0; c < 4; c++) begin
                step(c == 0, 0, 0, 0, 0);
                if (anim_frame != last) toggles++;
                last = anim_frame;
            end
        end
        chk("anim toggles", toggles, 2);

        // asynchronous reset in the middle of a tick pair
        step(1, 0, 0, 0, 0);
        #2 reset_n = 1'b0;
        #1 chk("async reset tick", game_tick, 0);
        chk("async reset state", player_state, S_IDLE);
        step(0, 0, 0, 0, 0);
        reset_n = 1'b1;

        // randomized run
        for (int i = 0; i < 15000 && n_bad < 40; i++) begin
            bit bu, bd;
            bu = button_up; bd = button_down;
            if ($urandom_range(3) == 0) bu = !bu;
            if ($urandom_range(7) == 0) bd = !bd;
            step($urandom_range(4) == 0, bu, bd, $urandom_range(79) == 0, $urandom_range(1) == 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
